// File: rtl/gf128_pkg.sv
// gf128_pkg
// Shared constants and types for the GF(2^128) modular reducer.
//   GF128_POLY_LOW : low-order terms of x^128 + x^7 + x^2 + x + 1 (below x^128)
//   GF128_W        : width of a reduced field element
//   GF128_PW       : width of the unreduced carry-less product
//   gf128_state_e  : reducer FSM states
package gf128_pkg;

  localparam logic [7:0] GF128_POLY_LOW = 8'h87;
  localparam int         GF128_W        = 128;
  localparam int         GF128_PW       = 256;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } gf128_state_e;

endpackage

// File: rtl/gf128_fold_step.sv
// gf128_fold_step
// Combinational single fold step of the GF(2^128) reduction. If bit k of the
// working value is set, that bit is cleared and POLY_LOW is XORed into bits
// [k-121:k-128], since x^k = x^(k-128) * x^128 = x^(k-128) * POLY_LOW.
// Ports:
//   r_i [255:0] : working value before the fold
//   k_i [7:0]   : bit index being folded, always in 128..255
//   r_o [255:0] : working value after the fold
module gf128_fold_step
  import gf128_pkg::*;
(
  input  logic [GF128_PW-1:0] r_i,
  input  logic [7:0]          k_i,
  output logic [GF128_PW-1:0] r_o
);

  logic [GF128_PW-1:0] clearBit;
  logic [GF128_PW-1:0] foldMask;

  // k_i is never below 128, so k_i - 128 is simply its low seven bits.
  always_comb begin
    clearBit        = '0;
    clearBit[k_i]   = 1'b1;
    foldMask        = {{(GF128_PW-8){1'b0}}, GF128_POLY_LOW} << k_i[6:0];
    r_o             = r_i;
    if (r_i[k_i]) begin
      r_o = r_i ^ clearBit ^ foldMask;
    end
  end

endmodule

// File: rtl/gf128_reduce.sv
// gf128_reduce
// Iterative reducer of a 256-bit carry-less product modulo
// x^128 + x^7 + x^2 + x + 1, folding bit indices 255 down to 128 MSB-first.
// Optional build macro: GF128_REDUCE_FAST_EN
//   undefined : one fold per RUN cycle, 128 RUN cycles per result
//   defined   : eight chained folds per RUN cycle, 16 RUN cycles per result
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : one-cycle request, only honoured while idle
//   p     : unreduced product, captured on an accepted start
//   busy  : high while reducing
//   done  : one-cycle pulse, y valid from that cycle
//   y     : reduced result, held until the next done
module gf128_reduce
  import gf128_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [GF128_PW-1:0] p,
  output logic                busy,
  output logic                done,
  output logic [GF128_W-1:0]  y
);

`ifdef GF128_REDUCE_FAST_EN
  localparam int STEPS = 8;
`else
  localparam int STEPS = 1;
`endif

  // Index of the first fold in the final RUN cycle; its chain ends at k = 128.
  localparam logic [7:0] LAST_K = 8'(128 + STEPS - 1);
  localparam logic [7:0] K_DEC  = 8'(STEPS);

  gf128_state_e         state_q, state_d;
  logic [GF128_PW-1:0]  r_q, r_d;
  logic [7:0]           k_q, k_d;
  logic [GF128_W-1:0]   y_q, y_d;
  logic                 done_q, done_d;

  logic [GF128_PW-1:0]  chain [0:STEPS];

  // Chained folds are hazard-free: a fold at index k only writes at or below
  // k-121, never touching the higher indices still to be examined this cycle.
  assign chain[0] = r_q;

  for (genvar g = 0; g < STEPS; g++) begin : g_fold
    localparam logic [7:0] OFF = 8'(g);
    gf128_fold_step u_fold (
      .r_i (chain[g]),
      .k_i (k_q - OFF),
      .r_o (chain[g+1])
    );
  end

  // Next-state logic: capture on accepted start, fold while running, publish
  // the low half and pulse done after the fold that reaches k = 128.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    k_d     = k_q;
    y_d     = y_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          r_d     = p;
          k_d     = 8'd255;
          state_d = RUN;
        end
      end
      RUN: begin
        r_d = chain[STEPS];
        if (k_q == LAST_K) begin
          y_d     = chain[STEPS][GF128_W-1:0];
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          k_d = k_q - K_DEC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any in-flight reduction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      k_q     <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      k_q     <= k_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign y    = y_q;

endmodule

// File: tb/tb_gf128_reduce.sv
// tb_gf128_reduce
// Directed self-checking bench for gf128_reduce. Inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_gf128_reduce;

`ifdef GF128_REDUCE_FAST_EN
  localparam int N = 16;
`else
  localparam int N = 128;
`endif
  localparam int LIMIT = 400;

  logic         clk;
  logic         rst;
  logic         start;
  logic [255:0] p;
  logic         busy;
  logic         done;
  logic [127:0] y;

  int checks;
  int errors;

  gf128_reduce dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .p     (p),
    .busy  (busy),
    .done  (done),
    .y     (y)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something hangs beyond every bounded wait.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required done before limit");
    $fatal(1, "[TB] watchdog");
  end

  // Pulses start for one cycle with pIn, then counts cycles until done.
  // latency is counted from the start cycle; busyCycles counts busy-high
  // cycles before done; busyAtDone is busy sampled in the done cycle.
  task automatic applyStimulus(input logic [255:0] pIn, output int latency,
                               output int busyCycles, output logic busyAtDone,
                               output logic [127:0] yOut, output logic gotDone);
    @(negedge clk);
    p     = pIn;
    start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    latency    = 1;
    busyCycles = 0;
    busyAtDone = 1'b0;
    yOut       = '0;
    gotDone    = 1'b0;
    while (latency <= LIMIT && !gotDone) begin
      if (done) begin
        gotDone    = 1'b1;
        yOut       = y;
        busyAtDone = busy;
      end else begin
        if (busy) busyCycles++;
        @(negedge clk);
        latency++;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    p     = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || y !== 128'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: busy=%b done=%b y=%h, required busy=0 done=0 y=0", busy, done, y);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [255:0] vecP [4];
    logic [127:0] vecY [4];
    int lat, bc;
    logic bad, got;
    logic [127:0] yo;
    vecP[0] = 256'h1 << 128;  vecY[0] = 128'h87;
    vecP[1] = 256'h1 << 127;  vecY[1] = 128'h1 << 127;
    vecP[2] = 256'h1 << 255;  vecY[2] = 128'h8000_0000_0000_0000_0000_0000_0000_2049;
    vecP[3] = {126'h0, 2'b11, 128'h1234};  vecY[3] = 128'h13bd;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecP[i], lat, bc, bad, yo, got);
      checks++;
      if (!got) begin
        errors++;
        $display("[TB] FAIL vector%0d_timeout: no done within %0d cycles, required done", i, LIMIT);
      end else if (yo !== vecY[i]) begin
        errors++;
        $display("[TB] FAIL vector%0d_y: got %h, required %h", i, yo, vecY[i]);
      end
      checks++;
      if (dut.r_q[255:128] !== 128'h0) begin
        errors++;
        $display("[TB] FAIL vector%0d_upper_zero: r[255:128]=%h, required 0", i, dut.r_q[255:128]);
      end
    end
  endtask

  task automatic test_zero_latency();
    int lat, bc;
    logic bad, got;
    logic [127:0] yo;
    applyStimulus(256'h0, lat, bc, bad, yo, got);
    checks++;
    if (!got || lat != N + 1) begin
      errors++;
      $display("[TB] FAIL zero_latency: done after %0d cycles (seen=%b), required %0d", lat, got, N + 1);
    end
    checks++;
    if (yo !== 128'h0) begin
      errors++;
      $display("[TB] FAIL zero_y: got %h, required 0", yo);
    end
    checks++;
    if (bc != N || bad !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_busy: busy cycles %0d busy@done %b, required %0d and 0", bc, bad, N);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || y !== 128'h0) begin
      errors++;
      $display("[TB] FAIL zero_done_pulse: done=%b y=%h after done cycle, required done=0 y=0", done, y);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    logic got;
    @(negedge clk);
    p     = 256'h1 << 128;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    got   = 1'b0;
    repeat (5) begin
      @(negedge clk);
      lat++;
    end
    p     = 256'h1 << 255;
    start = 1'b1;
    @(negedge clk);
    lat++;
    start = 1'b0;
    p     = {256{1'b1}};
    while (lat <= LIMIT && !got) begin
      if (done) got = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    checks++;
    if (!got || lat != N + 1) begin
      errors++;
      $display("[TB] FAIL ignore_latency: done after %0d cycles (seen=%b), required %0d", lat, got, N + 1);
    end
    checks++;
    if (y !== 128'h87) begin
      errors++;
      $display("[TB] FAIL ignore_y: got %h, required %h", y, 128'h87);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignore_no_restart: busy=%b after done, required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic bad, got;
    logic [127:0] yo;
    logic yHeld;
    applyStimulus(256'h1 << 128, lat, bc, bad, yo, got);
    checks++;
    if (!got || yo !== 128'h87) begin
      errors++;
      $display("[TB] FAIL b2b_first: y=%h seen=%b, required %h", yo, got, 128'h87);
    end
    // Now in the done cycle: start here must be accepted.
    p     = 256'h1 << 255;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    got   = 1'b0;
    yHeld = 1'b1;
    while (lat <= LIMIT && !got) begin
      if (done) got = 1'b1;
      else begin
        if (y !== 128'h87) yHeld = 1'b0;
        @(negedge clk);
        lat++;
      end
    end
    checks++;
    if (!got || lat != N + 1) begin
      errors++;
      $display("[TB] FAIL b2b_latency: second done after %0d cycles (seen=%b), required %0d", lat, got, N + 1);
    end
    checks++;
    if (y !== 128'h8000_0000_0000_0000_0000_0000_0000_2049) begin
      errors++;
      $display("[TB] FAIL b2b_y: got %h, required %h", y, 128'h8000_0000_0000_0000_0000_0000_0000_2049);
    end
    checks++;
    if (!yHeld) begin
      errors++;
      $display("[TB] FAIL b2b_y_hold: y changed before second done, required held at %h", 128'h87);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, resetAt;
    logic bad, got, sawDone;
    logic [127:0] yo;
    resetAt = (N > 50) ? 50 : N / 2;
    @(negedge clk);
    p     = 256'h1 << 255;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (resetAt - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || y !== 128'h0) begin
      errors++;
      $display("[TB] FAIL midrun_reset: busy=%b done=%b y=%h, required busy=0 done=0 y=0", busy, done, y);
    end
    sawDone = 1'b0;
    repeat (N + 10) begin
      @(negedge clk);
      if (done || busy) sawDone = 1'b1;
    end
    checks++;
    if (sawDone) begin
      errors++;
      $display("[TB] FAIL midrun_no_done: activity seen after reset=%b, required 0", sawDone);
    end
    applyStimulus(256'h1 << 128, lat, bc, bad, yo, got);
    checks++;
    if (!got || lat != N + 1 || yo !== 128'h87) begin
      errors++;
      $display("[TB] FAIL midrun_restart: lat=%0d y=%h seen=%b, required lat=%0d y=%h", lat, yo, got, N + 1, 128'h87);
    end
  endtask

  // Scenario sequence.
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    p      = '0;
    test_reset();
    test_vectors();
    test_zero_latency();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
